// File: rtl/ram_copy_pkg.sv
// ram_copy_pkg: shared types for the RAM copy/fill engine
package ram_copy_pkg;
    typedef enum logic {OP_COPY, OP_FILL} op_e;
    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR, S_DONE} state_e;
    typedef enum logic [1:0] {ST_OK, ST_ABORTED, ST_TIMEOUT} status_e;
endpackage

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: single-command COPY/FILL initiator on a 1-cycle single-port RAM with XOR checksum
module ram_copy_engine
    import ram_copy_pkg::*;
#(
    parameter int LenW          = 16,
    parameter int TimeoutCycles = 15
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_op_i,
    input  logic [31:0]     cmd_src_i,
    input  logic [31:0]     cmd_dst_i,
    input  logic [LenW-1:0] cmd_len_i,
    input  logic [31:0]     cmd_pattern_i,
    input  logic            abort_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [1:0]      status_o,
    output logic [31:0]     checksum_o,
    output logic [LenW-1:0] words_done_o
);
    localparam int TW = $clog2(TimeoutCycles + 1);
    state_e          r_state;
    op_e             r_op;
    status_e         r_status;
    logic [29:0]     r_src, r_dst, r_addr;
    logic [LenW-1:0] r_rem, r_words;
    logic [31:0]     r_pat, r_wdata, r_csum;
    logic [TW-1:0]   r_tmo;
    logic            r_abort, r_req, r_we, r_done;
    logic            w_abort, w_unused;
    assign w_abort      = r_abort || abort_i;
    assign w_unused     = ^{cmd_src_i[1:0], cmd_dst_i[1:0]};
    assign cmd_ready_o  = r_state == S_IDLE;
    assign busy_o       = r_state != S_IDLE;
    assign mem_req_o    = r_req;
    assign mem_we_o     = r_we;
    assign mem_be_o     = {4{r_we}};
    assign mem_addr_o   = {r_addr, 2'b00};
    assign mem_wdata_o  = r_wdata;
    assign done_o       = r_done;
    assign status_o     = r_status;
    assign checksum_o   = r_csum;
    assign words_done_o = r_words;
    // Memory-facing outputs are loaded with the values for the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_op     <= OP_COPY;
            r_status <= ST_OK;
            r_src    <= '0;
            r_dst    <= '0;
            r_addr   <= '0;
            r_rem    <= '0;
            r_words  <= '0;
            r_pat    <= '0;
            r_wdata  <= '0;
            r_csum   <= '0;
            r_tmo    <= '0;
            r_abort  <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && abort_i) r_abort <= 1'b1;
            case (r_state)
                S_IDLE: if (cmd_valid_i) begin
                    r_op     <= op_e'(cmd_op_i);
                    r_src    <= cmd_src_i[31:2];
                    r_dst    <= cmd_dst_i[31:2];
                    r_rem    <= cmd_len_i;
                    r_pat    <= cmd_pattern_i;
                    r_csum   <= '0;
                    r_words  <= '0;
                    r_status <= ST_OK;
                    r_abort  <= 1'b0;
                    if (cmd_len_i == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (op_e'(cmd_op_i) == OP_COPY) begin
                        r_state <= S_RD_REQ;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= cmd_src_i[31:2];
                    end else begin
                        r_state <= S_WR;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= cmd_dst_i[31:2];
                        r_wdata <= cmd_pattern_i;
                    end
                end
                S_RD_REQ: begin
                    r_state <= S_RD_WAIT;
                    r_req   <= 1'b0;
                    r_tmo   <= '0;
                end
                S_RD_WAIT: if (mem_rvalid_i) begin
                    r_state <= S_WR;
                    r_req   <= 1'b1;
                    r_we    <= 1'b1;
                    r_addr  <= r_dst;
                    r_wdata <= mem_rdata_i;
                end else if (r_tmo == TW'(TimeoutCycles - 1)) begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_status <= ST_TIMEOUT;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
                S_WR: begin
                    r_csum  <= r_csum ^ r_wdata;
                    r_words <= r_words + LenW'(1);
                    r_src   <= r_src + 30'd1;
                    r_dst   <= r_dst + 30'd1;
                    r_rem   <= r_rem - LenW'(1);
                    // Completion wins over a late abort on the final word.
                    if (r_rem == LenW'(1) || w_abort) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_req    <= 1'b0;
                        r_we     <= 1'b0;
                        r_status <= r_rem == LenW'(1) ? ST_OK : ST_ABORTED;
                    end else if (r_op == OP_COPY) begin
                        r_state <= S_RD_REQ;
                        r_we    <= 1'b0;
                        r_addr  <= r_src + 30'd1;
                    end else begin
                        r_addr  <= r_dst + 30'd1;
                        r_wdata <= r_pat;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: directed COPY/FILL commands against a 1-cycle RAM responder and a sequential memory model
module tb_ram_copy_engine;
    import ram_copy_pkg::*;
    localparam int LenW = 16;
    logic            clk_i = 1'b0, rst_ni = 1'b0;
    logic            cmd_valid_i = 1'b0, cmd_ready_o, cmd_op_i = 1'b0, abort_i = 1'b0;
    logic [31:0]     cmd_src_i = '0, cmd_dst_i = '0, cmd_pattern_i = '0;
    logic [LenW-1:0] cmd_len_i = '0;
    logic            mem_req_o, mem_we_o, mem_rvalid_i, busy_o, done_o;
    logic [3:0]      mem_be_o;
    logic [31:0]     mem_addr_o, mem_wdata_o, mem_rdata_i, checksum_o;
    logic [1:0]      status_o;
    logic [LenW-1:0] words_done_o;
    logic            withhold = 1'b0;
    int              n_cmp = 0, n_bad = 0;
    logic [31:0]     ram [logic [29:0]];
    logic [31:0]     mdl [logic [29:0]];
    logic [31:0]     q_wa[$], q_wd[$], q_ra[$];

    always #5 clk_i = ~clk_i;

    ram_copy_engine #(.LenW(LenW), .TimeoutCycles(15)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i),
        .cmd_pattern_i(cmd_pattern_i), .abort_i(abort_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o),
        .status_o(status_o), .checksum_o(checksum_o), .words_done_o(words_done_o)
    );

    function automatic logic [31:0] ram_rd(input logic [29:0] a);
        return ram.exists(a) ? ram[a] : 32'h0;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [29:0] a);
        return mdl.exists(a) ? mdl[a] : 32'h0;
    endfunction

    // Single-port RAM responder: read data one cycle after the request.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
        end else begin
            mem_rvalid_i <= mem_req_o && !mem_we_o && !withhold;
            mem_rdata_i  <= ram_rd(mem_addr_o[31:2]);
            if (mem_req_o && mem_we_o) ram[mem_addr_o[31:2]] = mem_wdata_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && mem_req_o) begin
            if (mem_we_o) begin
                chk("wr_expected", 32'(q_wa.size() > 0), 32'd1);
                if (q_wa.size() > 0) begin
                    chk("wr_addr", mem_addr_o, q_wa.pop_front());
                    chk("wr_data", mem_wdata_o, q_wd.pop_front());
                    chk("wr_be", 32'(mem_be_o), 32'hF);
                end
            end else begin
                chk("rd_expected", 32'(q_ra.size() > 0), 32'd1);
                if (q_ra.size() > 0) begin
                    chk("rd_addr", mem_addr_o, q_ra.pop_front());
                    chk("rd_be", 32'(mem_be_o), 32'h0);
                end
            end
        end
    end

    task automatic chk_reset(input string nm);
        chk({nm, "_ctl"}, 32'({mem_req_o, mem_we_o, mem_be_o, busy_o, done_o, status_o}), 32'h0);
        chk({nm, "_addr"}, mem_addr_o, 32'h0);
        chk({nm, "_wdata"}, mem_wdata_o, 32'h0);
        chk({nm, "_csum"}, checksum_o, 32'h0);
        chk({nm, "_words"}, 32'(words_done_o), 32'h0);
        chk({nm, "_ready"}, 32'(cmd_ready_o), 32'h1);
    endtask

    // Expected traffic follows from processing words in ascending order against the model memory.
    task automatic start_cmd(input op_e op, input logic [31:0] src, input logic [31:0] dst, input int len,
                             input logic [31:0] pat, input int nw, input int nr);
        int w;
        for (int i = 0; i < nr; i++) q_ra.push_back({src[31:2] + 30'(i), 2'b00});
        for (int i = 0; i < nw; i++) begin
            logic [29:0] da;
            logic [31:0] d;
            da = dst[31:2] + 30'(i);
            d  = (op == OP_FILL) ? pat : mdl_rd(src[31:2] + 30'(i));
            mdl[da] = d;
            q_wa.push_back({da, 2'b00});
            q_wd.push_back(d);
        end
        w = 0;
        while (!cmd_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        chk("ready_before_cmd", 32'(cmd_ready_o), 32'h1);
        @(negedge clk_i);
        cmd_valid_i   = 1'b1;
        cmd_op_i      = op;
        cmd_src_i     = src;
        cmd_dst_i     = dst;
        cmd_len_i     = LenW'(len);
        cmd_pattern_i = pat;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic finish_cmd(input string nm, input int exp_cyc, input status_e exp_st, input int exp_words,
                              input logic [31:0] exp_csum, input int abort_cyc);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 100 && !seen) begin
            @(negedge clk_i);
            cyc++;
            if (done_o) seen = 1'b1;
            abort_i = (cyc == abort_cyc);
        end
        abort_i = 1'b0;
        chk({nm, "_done_seen"}, 32'(seen), 32'h1);
        chk({nm, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({nm, "_status"}, 32'(status_o), 32'(exp_st));
        chk({nm, "_words"}, 32'(words_done_o), 32'(exp_words));
        chk({nm, "_csum"}, checksum_o, exp_csum);
        chk({nm, "_wr_left"}, 32'(q_wa.size()), 32'h0);
        chk({nm, "_rd_left"}, 32'(q_ra.size()), 32'h0);
        @(negedge clk_i);
        chk({nm, "_pulse"}, 32'({done_o, busy_o, cmd_ready_o}), 32'b001);
    endtask

    initial begin
        ram[0] = 32'd1; ram[1] = 32'd2; ram[2] = 32'd4;
        mdl[0] = 32'd1; mdl[1] = 32'd2; mdl[2] = 32'd4;
        repeat (2) @(negedge clk_i);
        chk_reset("reset");
        rst_ni = 1'b1;

        start_cmd(OP_FILL, 32'h100, 32'h100, 4, 32'hA5A5_0F0F, 4, 0);
        finish_cmd("fill4", 5, ST_OK, 4, 32'h0, -1);
        chk("fill4_ram", ram_rd(30'h43), 32'hA5A5_0F0F);

        start_cmd(OP_COPY, 32'h0, 32'h200, 3, 32'h0, 3, 3);
        finish_cmd("copy3", 10, ST_OK, 3, 32'h7, -1);
        chk("copy3_ram", {ram_rd(30'h80)[7:0], ram_rd(30'h81)[7:0], ram_rd(30'h82)[7:0]}, 32'h010204);

        start_cmd(OP_FILL, 32'h0, 32'h800, 0, 32'h1234, 0, 0);
        finish_cmd("fill0", 1, ST_OK, 0, 32'h0, -1);
        start_cmd(OP_COPY, 32'h0, 32'h800, 0, 32'h0, 0, 0);
        finish_cmd("copy0", 1, ST_OK, 0, 32'h0, -1);

        @(negedge clk_i) abort_i = 1'b1;
        @(negedge clk_i) abort_i = 1'b0;
        start_cmd(OP_COPY, 32'h0, 32'h500, 8, 32'h0, 3, 3);
        finish_cmd("abort", 10, ST_ABORTED, 3, 32'h7, 8);

        start_cmd(OP_FILL, 32'h0, 32'h600, 2, 32'h1234_5678, 2, 0);
        finish_cmd("abort_last", 3, ST_OK, 2, 32'h0, 2);

        withhold = 1'b1;
        start_cmd(OP_COPY, 32'h0, 32'h300, 2, 32'h0, 0, 1);
        finish_cmd("timeout", 17, ST_TIMEOUT, 0, 32'h0, -1);
        withhold = 1'b0;
        chk("timeout_ram", ram_rd(30'hC0), 32'h0);

        start_cmd(OP_COPY, 32'h200, 32'h204, 3, 32'h0, 3, 3);
        finish_cmd("overlap", 10, ST_OK, 3, 32'h1, -1);
        chk("overlap_ram", ram_rd(30'h83), 32'h1);

        start_cmd(OP_FILL, 32'h0, 32'hFFFF_FFF8, 3, 32'hDEAD_BEEF, 3, 0);
        finish_cmd("wrap", 4, ST_OK, 3, 32'hDEAD_BEEF, -1);
        chk("wrap_ram_hi", ram_rd(30'h3FFF_FFFF), 32'hDEAD_BEEF);
        chk("wrap_ram_lo", ram_rd(30'h0), 32'hDEAD_BEEF);

        start_cmd(OP_COPY, 32'h100, 32'h700, 5, 32'h0, 5, 5);
        repeat (4) begin
            @(negedge clk_i);
            chk("midrst_no_done", 32'(done_o), 32'h0);
        end
        rst_ni = 1'b0;
        #1 chk_reset("midrst");
        q_wa.delete();
        q_wd.delete();
        q_ra.delete();
        repeat (2) begin
            @(negedge clk_i);
            chk("midrst_held", 32'({done_o, busy_o, mem_req_o}), 32'h0);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_ready", 32'({cmd_ready_o, done_o}), 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
